// File: rtl/fetch_pc_unit.sv
// Fetch PC unit: holds the PC, issues word fetches to imem and buffers returned words for decode.
// Defining MISALIGN_TRAP_EN adds the TRAP state and the misalign_trap output.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned MAX_OUTSTAND = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        misalign_trap
`endif
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUTSTAND + 1);
  localparam int unsigned TW = (MAX_OUTSTAND > 1) ? $clog2(MAX_OUTSTAND) : 1;

  typedef enum logic [1:0] {StRun, StFlush, StTrap} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [OW-1:0]   out_q, out_d;
  logic [OW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   rptr_q, rptr_d, wptr_q, wptr_d;
  logic [31:0]     fifo_instr_q [FIFO_DEPTH];
  logic [31:0]     fifo_pc_q    [FIFO_DEPTH];
  logic [31:0]     tag_q        [MAX_OUTSTAND];
  logic [TW-1:0]   tag_wr_q, tag_rd_q;
  logic            grant, drop_rsp, push, pop, take_redirect;
  logic [31:0]     occupancy;
`ifdef MISALIGN_TRAP_EN
  logic            trap_q, trap_d, redirect_misaligned;
  assign misalign_trap = trap_q;
`endif

  function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
    return (p == TW'(MAX_OUTSTAND - 1)) ? '0 : p + 1'b1;
  endfunction

  assign if_valid = (cnt_q != '0);
  assign if_instr = fifo_instr_q[rptr_q];
  assign if_pc    = fifo_pc_q[rptr_q];

  always_comb begin
    occupancy = 32'(out_q) + 32'(cnt_q);
    imem_req  = !rst && (state_q == StRun) && !redirect_valid &&
                (occupancy < FIFO_DEPTH) && (32'(out_q) < MAX_OUTSTAND);
    imem_addr = pc_q;
    grant     = imem_req && imem_gnt;
`ifdef MISALIGN_TRAP_EN
    redirect_misaligned = (redirect_pc[1:0] != 2'b00);
    // Misaligned targets are ignored while already trapped.
    take_redirect = redirect_valid && !((state_q == StTrap) && redirect_misaligned);
`else
    take_redirect = redirect_valid;
`endif
    drop_rsp = imem_rvalid && (drop_q != '0);
    push     = imem_rvalid && !drop_rsp && !take_redirect;
    pop      = if_valid && if_ready && !take_redirect;
    out_d    = out_q + OW'(grant) - OW'(imem_rvalid);

    pc_d    = grant ? pc_q + 32'd4 : pc_q;
    drop_d  = drop_q - OW'(drop_rsp);
    cnt_d   = cnt_q + CW'(push) - CW'(pop);
    rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
    wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
    state_d = state_q;
`ifdef MISALIGN_TRAP_EN
    trap_d  = trap_q;
`endif
    if ((state_q == StFlush) && (drop_d == '0)) state_d = StRun;

    if (take_redirect) begin
      pc_d    = redirect_pc & 32'hFFFF_FFFC;
      // Everything still in flight after this cycle belongs to the old stream.
      drop_d  = out_d;
      cnt_d   = '0;
      rptr_d  = '0;
      wptr_d  = '0;
      state_d = (out_d != '0) ? StFlush : StRun;
`ifdef MISALIGN_TRAP_EN
      trap_d  = redirect_misaligned;
      if (redirect_misaligned) state_d = StTrap;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StRun;
      pc_q     <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
      cnt_q    <= '0;
      rptr_q   <= '0;
      wptr_q   <= '0;
      tag_wr_q <= '0;
      tag_rd_q <= '0;
`ifdef MISALIGN_TRAP_EN
      trap_q   <= 1'b0;
`endif
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_instr_q[i] <= '0;
        fifo_pc_q[i]    <= '0;
      end
      for (int unsigned i = 0; i < MAX_OUTSTAND; i++) tag_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
`ifdef MISALIGN_TRAP_EN
      trap_q  <= trap_d;
`endif
      // Tags track every request, dropped or not, so they stay in step with responses.
      if (grant) begin
        tag_q[tag_wr_q] <= pc_q;
        tag_wr_q        <= tag_inc(tag_wr_q);
      end
      if (imem_rvalid) tag_rd_q <= tag_inc(tag_rd_q);
      if (push) begin
        fifo_instr_q[wptr_q] <= imem_rdata;
        fifo_pc_q[wptr_q]    <= tag_q[tag_rd_q];
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed vector table, corner-case sequences and a randomized run
// against a queue-based reference model.
`timescale 1ns/1ps
module tb_fetch_pc_unit;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXO  = 2;
`ifdef MISALIGN_TRAP_EN
  localparam bit TrapEn = 1'b1;
`else
  localparam bit TrapEn = 1'b0;
`endif
  localparam int MRun = 0, MFlush = 1, MTrap = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid, imem_req, imem_gnt, imem_rvalid, if_valid, if_ready, trap_out;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, if_instr, if_pc;

  always #5 clk = ~clk;

  fetch_pc_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH), .MAX_OUTSTAND(MAXO)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_valid(if_valid),
    .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc)
`ifdef MISALIGN_TRAP_EN
    , .misalign_trap(trap_out)
`endif
  );
`ifndef MISALIGN_TRAP_EN
  assign trap_out = 1'b0;
`endif

  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct {
    bit gnt; bit rv; logic [31:0] raddr; bit ready;
    bit exp_req; logic [31:0] exp_addr; bit exp_valid; logic [31:0] exp_pc;
  } vec_t;

  ent_t        m_fifo[$];
  logic [31:0] m_tags[$];
  mreq_t       mem_q[$];
  logic [31:0] m_pc;
  int          m_drop, m_mode, cyc, lat_max, checks, failures;
  bit          m_trap;
  logic        o_req, o_valid, o_grant, o_pop;
  logic [31:0] o_addr, o_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit model_req(input bit rv);
    return !rst && m_mode == MRun && !rv && (m_tags.size() + m_fifo.size() < DEPTH) &&
           (m_tags.size() < MAXO);
  endfunction

  task automatic do_reset();
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; if_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_imem_req", imem_req, 0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
`ifdef MISALIGN_TRAP_EN
    chk("rst_trap", trap_out, 0);
`endif
    m_fifo.delete(); m_tags.delete(); mem_q.delete();
    m_pc = 32'h0; m_drop = 0; m_mode = MRun; m_trap = 1'b0;
    rst = 1'b0;
  endtask

  // One clock: drive inputs, compare against the model, then advance the model.
  task automatic cycle(input bit gnt, input bit ready, input bit rv_en, input bit rv,
                       input logic [31:0] rpc);
    bit req, rsp, take, mis;
    logic [31:0] tag;
    mreq_t rd;
    imem_gnt = gnt; if_ready = ready; redirect_valid = rv; redirect_pc = rpc;
    rsp = rv_en && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imem_rvalid = rsp;
    imem_rdata  = rsp ? mem_word(mem_q[0].addr) : 32'h0;
    #2;
    req = model_req(rv);
    chk("imem_req", imem_req, req);
    chk("imem_addr", imem_addr, m_pc);
    chk("if_valid", if_valid, m_fifo.size() > 0);
    if (m_fifo.size() > 0) begin
      chk("if_pc", if_pc, m_fifo[0].pc);
      chk("if_instr", if_instr, m_fifo[0].instr);
    end
`ifdef MISALIGN_TRAP_EN
    chk("misalign_trap", trap_out, m_trap);
`endif
    o_req = imem_req; o_addr = imem_addr; o_grant = imem_req && gnt;
    o_valid = if_valid; o_pc = if_pc; o_pop = if_valid && ready;
    @(posedge clk);
    mis  = TrapEn && (rpc[1:0] != 2'b00);
    take = rv && !(m_mode == MTrap && mis);
    if (ready && m_fifo.size() > 0 && !take) void'(m_fifo.pop_front());
    if (rsp) begin
      rd  = mem_q.pop_front();
      tag = m_tags.pop_front();
      if (!take) begin
        if (m_drop > 0) m_drop--;
        else m_fifo.push_back('{tag, mem_word(rd.addr)});
      end
    end
    if (req && gnt) begin
      m_tags.push_back(m_pc);
      mem_q.push_back('{m_pc, cyc + 1 + int'($urandom_range(0, lat_max))});
      m_pc = m_pc + 32'd4;
    end
    if (take) begin
      m_fifo.delete();
      m_drop = m_tags.size();
      m_pc   = rpc & 32'hFFFF_FFFC;
      m_trap = mis;
      m_mode = mis ? MTrap : (m_drop > 0 ? MFlush : MRun);
    end else if (m_mode == MFlush && m_drop == 0) begin
      m_mode = MRun;
    end
    cyc++;
    #1;
  endtask

  task automatic run_expect(input string nm, input logic [31:0] start);
    logic [31:0] first_addr, first_pc;
    bit got_a, got_p;
    int stale;
    got_a = 0; got_p = 0; stale = 0; first_addr = '1; first_pc = '1;
    for (int k = 0; k < 24; k++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      if (o_grant && !got_a) begin got_a = 1; first_addr = o_addr; end
      if (o_valid && !got_p) begin got_p = 1; first_pc = o_pc; end
      if (o_valid && (o_pc < start || o_pc >= start + 32'h100)) stale++;
    end
    chk({nm, "_first_addr"}, first_addr, start);
    chk({nm, "_first_pc"}, first_pc, start);
    chk({nm, "_stale_pc"}, stale, 0);
  endtask

  initial begin
    vec_t vecs[8];
    int ngr, npop;
    bit seen, rv;
    logic [31:0] rpc;
    checks = 0; failures = 0; cyc = 0; lat_max = 0;
    for (int n = 0; n < 8; n++)
      vecs[n] = '{1'b1, n >= 1, 32'(4 * (n - 1)), 1'b1, 1'b1, 32'(4 * n), n >= 2, 32'(4 * (n - 2))};

    // Steady-state streaming, one instruction per cycle.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      imem_gnt = vecs[i].gnt; imem_rvalid = vecs[i].rv; if_ready = vecs[i].ready;
      imem_rdata = mem_word(vecs[i].raddr);
      #2;
      chk("t1_req", imem_req, vecs[i].exp_req);
      chk("t1_addr", imem_addr, vecs[i].exp_addr);
      chk("t1_valid", if_valid, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        chk("t1_pc", if_pc, vecs[i].exp_pc);
        chk("t1_instr", if_instr, mem_word(vecs[i].exp_pc));
      end
      @(posedge clk); #1;
    end

    // Backpressure fills the buffer, then drains in order.
    do_reset();
    ngr = 0;
    repeat (10) begin
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      if (o_grant) ngr++;
    end
    chk("t2_grants", ngr, 4);
    chk("t2_req_stalled", o_req, 0);
    npop = 0; seen = 0;
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      if (o_pop && npop < 4) begin chk("t2_pop_pc", o_pc, 32'(4 * npop)); npop++; end
      if (o_grant && !seen) begin seen = 1; chk("t2_resume_addr", o_addr, 32'h10); end
    end
    chk("t2_pops", npop, 4);

    // Redirect with two requests outstanding.
    do_reset();
    repeat (3) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    repeat (2) cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h100);
    run_expect("t3", 32'h100);

    // Redirect coinciding with a response and a pop.
    do_reset();
    repeat (4) cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h180);
    run_expect("t4", 32'h180);

    // Back-to-back redirects.
    do_reset();
    repeat (3) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h200);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h300);
    run_expect("t5", 32'h300);

    // Misaligned redirect target.
    do_reset();
    repeat (3) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h102);
`ifdef MISALIGN_TRAP_EN
    repeat (4) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("t6_trap_set", trap_out, 1);
    chk("t6_no_req", o_req, 0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h206);
    chk("t6_trap_kept", trap_out, 1);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h40);
    chk("t6_trap_clear", trap_out, 0);
    run_expect("t6", 32'h40);
`else
    run_expect("t6", 32'h100);
`endif

    // Randomized traffic against the model.
    do_reset();
    lat_max = 2;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        rv  = ($urandom_range(0, 15) == 0);
        rpc = 32'($urandom) & 32'h0000_0FFF;
        if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
        if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF8;
        cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
              $urandom_range(0, 3) != 0, rv, rpc);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
